// File: rtl/wb_orclr_bank.sv
// rtl/wb_orclr_bank.sv - N_CH x WIDTH sticky OR-set / write-1-to-clear event bank on a pipelined Wishbone slave
// Define ORCLR_IRQ_EN to build the per-channel MASK registers and the combined irq_o.
module wb_orclr_bank #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 32,
  parameter int AW    = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [AW-1:0]           wb_adr_i,
  input  logic [3:0]              wb_sel_i,
  input  logic [31:0]             wb_dat_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  output logic                    wb_stall_o,
  output logic [31:0]             wb_dat_o,
  input  logic [N_CH*WIDTH-1:0]   ev_i,
  output logic [N_CH*WIDTH-1:0]   status_o,
  output logic                    irq_o
);
  localparam int CW = AW - 3;

  logic [WIDTH-1:0] status_q [N_CH];
  logic [N_CH-1:0]  st_sel, st_sel_q;
  logic [WIDTH-1:0] rd_word, wdat_q;
  logic [31:0]      rdata_q;
  logic             mapped, req;
  logic             rd_busy, wr_busy, rd_v1, wr_v1, wr_v2, err1, err2;
  logic             unused;

`ifdef ORCLR_IRQ_EN
  logic [WIDTH-1:0] mask_q [N_CH];
  logic [N_CH-1:0]  mk_sel, mk_sel_q;
  logic             irq_any, irq_q;
`endif

  assign unused = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i};

  // Address decode: channel = adr[AW-1:3], adr[2] selects MASK over STATUS.
  always_comb begin
    st_sel  = '0;
    rd_word = '0;
`ifdef ORCLR_IRQ_EN
    mk_sel  = '0;
`endif
    for (int k = 0; k < N_CH; k++) begin
      if (wb_adr_i[AW-1:3] == CW'(k)) begin
        if (!wb_adr_i[2]) begin
          st_sel[k] = 1'b1;
          rd_word   = status_q[k];
        end
`ifdef ORCLR_IRQ_EN
        else begin
          mk_sel[k] = 1'b1;
          rd_word   = mask_q[k];
        end
`endif
      end
    end
  end

`ifdef ORCLR_IRQ_EN
  assign mapped = (|st_sel) | (|mk_sel);
`else
  assign mapped = |st_sel;
`endif

  // Busy flags plus the response itself block re-acceptance of a held request.
  assign req        = wb_cyc_i & wb_stb_i & ~rd_busy & ~wr_busy & ~wb_ack_o & ~wb_err_o;
  assign wb_stall_o = ~(wb_ack_o | wb_err_o) & wb_cyc_i & wb_stb_i;
  assign wb_rty_o   = 1'b0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_busy  <= 1'b0;
      wr_busy  <= 1'b0;
      rd_v1    <= 1'b0;
      wr_v1    <= 1'b0;
      wr_v2    <= 1'b0;
      err1     <= 1'b0;
      err2     <= 1'b0;
      rdata_q  <= '0;
      wdat_q   <= '0;
      st_sel_q <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      rd_v1 <= req & ~wb_we_i;
      wr_v1 <= req & wb_we_i;
      wr_v2 <= wr_v1;
      err2  <= err1;
      if (req) begin
        err1     <= ~mapped;
        rdata_q  <= 32'(rd_word);
        wdat_q   <= wb_dat_i[WIDTH-1:0];
        st_sel_q <= st_sel;
      end
      if (req & ~wb_we_i)
        rd_busy <= 1'b1;
      else if (rd_v1)
        rd_busy <= 1'b0;
      if (req & wb_we_i)
        wr_busy <= 1'b1;
      else if (wr_v2)
        wr_busy <= 1'b0;
      wb_ack_o <= (rd_v1 & ~err1) | (wr_v2 & ~err2);
      wb_err_o <= (rd_v1 & err1) | (wr_v2 & err2);
      wb_dat_o <= (rd_v1 & ~err1) ? rdata_q : '0;
    end
  end

  // Set wins: new events are ORed in after the write-1 clear is applied.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < N_CH; k++) begin
      if (rst_i)
        status_q[k] <= '0;
      else if (wr_v1 & st_sel_q[k])
        status_q[k] <= ev_i[k*WIDTH +: WIDTH] | (status_q[k] & ~wdat_q);
      else
        status_q[k] <= ev_i[k*WIDTH +: WIDTH] | status_q[k];
    end
  end

  always_comb begin
    status_o = '0;
    for (int k = 0; k < N_CH; k++)
      status_o[k*WIDTH +: WIDTH] = status_q[k];
  end

`ifdef ORCLR_IRQ_EN
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < N_CH; k++) begin
      if (rst_i)
        mask_q[k] <= '0;
      else if (wr_v1 & mk_sel_q[k])
        mask_q[k] <= wdat_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      mk_sel_q <= '0;
    else if (req)
      mk_sel_q <= mk_sel;
  end

  always_comb begin
    irq_any = 1'b0;
    for (int k = 0; k < N_CH; k++)
      irq_any = irq_any | (|(status_q[k] & mask_q[k]));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      irq_q <= 1'b0;
    else
      irq_q <= irq_any;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_orclr_bank.sv
// tb/tb_wb_orclr_bank.sv - randomized scoreboard bench for wb_orclr_bank against a behavioural register-bank model
module tb_wb_orclr_bank;
  localparam int N_CH = 4;
  localparam int W    = 16;
  localparam int AW   = 8;
  localparam int EVW  = N_CH * W;
`ifdef ORCLR_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic           clk = 1'b0, rst = 1'b1;
  logic           cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [AW-1:0]  adr = '0;
  logic [3:0]     sel = '0;
  logic [31:0]    wdat = '0;
  logic           ack, err, rty, stall, irq;
  logic [31:0]    rdat;
  logic [EVW-1:0] ev = '0;
  logic [EVW-1:0] status;

  wb_orclr_bank #(.N_CH(N_CH), .WIDTH(W), .AW(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_dat_i(wdat),
    .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .wb_stall_o(stall),
    .wb_dat_o(rdat), .ev_i(ev), .status_o(status), .irq_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t           sbq[$];
  int             vectors = 0, miscompares = 0, cyc_cnt = 0;
  logic [W-1:0]   m_status [N_CH];
  logic [W-1:0]   m_mask   [N_CH];
  logic           m_irq = 1'b0;
  bit             ap_st = 0, ap_mk = 0;
  int             ap_ch = 0;
  logic [W-1:0]   ap_d = '0;
  bit             ev_rand_en = 0;
  logic [EVW-1:0] ev_force = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc_cnt);
    end
  endtask

  function automatic logic [EVW-1:0] next_ev();
    logic [EVW-1:0] e;
    e = ev_force;
    if (ev_rand_en && $urandom_range(0, 3) == 0)
      e[$urandom_range(0, EVW-1)] = 1'b1;
    return e;
  endfunction

  // One clock: drive events, advance the model at the edge, check status/irq mid-cycle.
  task automatic step(input logic [EVW-1:0] ev_in);
    logic           any;
    logic [W-1:0]   clr;
    logic [EVW-1:0] flat;
    ev = ev_in;
    @(posedge clk);
    cyc_cnt++;
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        m_status[k] = '0;
        m_mask[k]   = '0;
      end
      m_irq = 1'b0;
    end else begin
      any = 1'b0;
      for (int k = 0; k < N_CH; k++)
        if ((m_status[k] & m_mask[k]) != 0) any = 1'b1;
      m_irq = IRQ_ON ? any : 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        clr = (ap_st && ap_ch == k) ? ap_d : '0;
        m_status[k] = ev_in[k*W +: W] | (m_status[k] & ~clr);
      end
      if (ap_mk) m_mask[ap_ch] = ap_d;
    end
    ap_st = 0;
    ap_mk = 0;
    @(negedge clk);
    for (int k = 0; k < N_CH; k++) flat[k*W +: W] = m_status[k];
    chk("status_o", status, flat);
    chk("irq_o", irq, m_irq);
  endtask

  task automatic bus(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
    exp_t e;
    int   ch;
    bit   ism, map;
    ch  = int'(a) / 8;
    ism = a[2];
    map = (ch < N_CH) && (!ism || IRQ_ON);
    e.err  = !map;
    e.due  = cyc_cnt + (w ? 3 : 2);
    e.data = '0;
    if (map && !w) e.data = 32'(ism ? m_mask[ch] : m_status[ch]);
    sbq.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = 4'($urandom);
    step(next_ev());
    if (w && map) begin
      ap_ch = ch;
      ap_st = !ism;
      ap_mk = ism;
      ap_d  = d[W-1:0];
    end
    step(next_ev());
    if (w) step(next_ev());
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step(next_ev());
  endtask

  // Monitor: pops the scoreboard whenever the slave responds.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (cyc && stb) chk("stall", stall, !(ack || err));
      chk("rty", rty, 0);
      if (ack || err) begin
        if (sbq.size() == 0)
          chk("unexpected_resp", {ack, err}, 2'b00);
        else begin
          e = sbq.pop_front();
          chk("resp_kind", {ack, err}, e.err ? 2'b01 : 2'b10);
          chk("resp_data", rdat, e.data);
          chk("resp_cycle", cyc_cnt, e.due);
        end
      end else if (sbq.size() > 0 && cyc_cnt > sbq[0].due + 4) begin
        chk("resp_timeout", cyc_cnt, sbq[0].due);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    logic [EVW-1:0] t;
    logic [AW-1:0]  a;
    int             kind, ch;

    step('0);
    step('0);
    rst = 1'b0;
    chk("reset_dat", rdat, 0);
    chk("reset_resp", {ack, err, stall}, 0);
    chk("reset_irq", irq, 0);
    chk("reset_status", status, 0);

    bus(1'b0, 8'h00, 32'h0);
    t = '0; t[W +: W] = 16'h00A5;
    step(t);
    bus(1'b0, 8'h08, 32'h0);
    chk("ch1_set", status[W +: W], 16'h00A5);
    bus(1'b1, 8'h08, 32'h0000_0005);
    bus(1'b0, 8'h08, 32'h0);
    chk("ch1_clr", status[W +: W], 16'h00A0);

    ev_force = '0; ev_force[0] = 1'b1;
    bus(1'b1, 8'h00, 32'h0000_0001);
    ev_force = '0;
    chk("set_wins", status[0], 1'b1);
    bus(1'b0, 8'h00, 32'h0);

    bus(1'b1, 8'h14, 32'h0000_0001);
    t = '0; t[2*W] = 1'b1;
    step(t);
    chk("irq_pre", irq, 0);
    step('0);
    chk("irq_rise", irq, IRQ_ON);
    bus(1'b1, 8'h10, 32'h0000_0001);
    step('0);
    chk("irq_fall", irq, 0);
    bus(1'b0, 8'h14, 32'h0);

    bus(1'b1, 8'h20, 32'hFFFF_FFFF);
    bus(1'b0, 8'h0C, 32'h0);
    bus(1'b1, 8'h04, 32'hFFFF_FFFF);
    bus(1'b0, 8'h04, 32'h0);
    bus(1'b0, 8'h08, 32'h0);

    ev_rand_en = 1;
    repeat (200) begin
      kind = $urandom_range(0, 2);
      ch   = $urandom_range(0, N_CH-1);
      case (kind)
        0:       a = AW'(ch * 8);
        1:       a = AW'(ch * 8 + 4);
        default: a = AW'($urandom_range(N_CH * 8, 255));
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      bus(1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) step(next_ev());
    end
    ev_rand_en = 0;

    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h00; wdat = 32'hFFFF_FFFF;
    step('0);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step('1);
    rst = 1'b0;
    repeat (4) step('0);
    chk("post_reset_status", status, 0);
    chk("post_reset_irq", irq, 0);
    bus(1'b0, 8'h00, 32'h0);
    bus(1'b0, 8'h04, 32'h0);

    repeat (8) step('0);
    chk("sb_drain", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_orclr_bank.md
# wb_orclr_bank

Parametrised bank of sticky event registers behind a pipelined Wishbone slave. It generalises the single OR-set/write-1-to-clear register to N_CH channels of WIDTH bits. Each channel has an optional interrupt mask, and the block drives one combined level interrupt. It sits between per-channel hardware event sources and the system Wishbone crossbar.

## Interface
Reset is synchronous and active-high. There is one clock.

Parameters:
- N_CH, default 4, number of event channels (1..16).
- WIDTH, default 32, event bits per channel (1..32).
- AW, default 8, byte-address width of wb_adr_i; must satisfy 2^AW ≥ 8·N_CH.

Ports:
- clk_i  in  1  system clock; all logic rises on this edge.
- rst_i  in  1  synchronous active-high reset.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  Wishbone cycle, strobe and write enable.
- wb_adr_i  in  AW  byte address; bits [1:0] are ignored.
- wb_sel_i  in  4  byte selects; ignored, accesses are whole-word.
- wb_dat_i  in  32  write data.
- wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o  out  1  Wishbone responses.
- wb_dat_o  out  32  read data.
- ev_i  in  N_CH·WIDTH  event inputs; channel k occupies bits [k·WIDTH +: WIDTH].
- status_o  out  N_CH·WIDTH  current sticky status of all channels.
- irq_o  out  1  combined interrupt.

## Operation
Address map (byte offsets):
- 8k is STATUS[k].
- 8k+4 is MASK[k], for k < N_CH.
- Every other offset is unmapped.

STATUS update, every cycle, per channel:
- Without a write: status ← ev_i | status.
- With a write of d: status ← ev_i | (status & ~d[WIDTH-1:0]).
- Set wins when a bit is set and cleared in the same cycle.

MASK behaviour:
- Plain read/write register.
- A bit value of 1 enables that status bit onto irq_o.

Data width rules:
- Read data bits [31:WIDTH] return 0.
- Write data bits [31:WIDTH] are ignored.

Unmapped accesses:
- Read or write to an unmapped address responds with wb_err_o instead of wb_ack_o, with the same latency.
- wb_dat_o returns 0.
- No state changes.

Interrupt: irq_o is registered, with irq_o ← OR over k of |(status[k] & mask[k]).

Bus handshake:
- Read-in-progress and write-in-progress flags hold off repeated requests until the response.
- wb_stall_o = ~(ack|err) & cyc & stb.
- wb_rty_o is always 0.
- One outstanding transaction at a time.

## Timing
Reset (rst_i high at a clock edge) clears:
- all STATUS and MASK registers;
- wb_dat_o, wb_ack_o, wb_err_o, irq_o;
- the in-progress flags;
- all pipeline registers.

A request in flight when reset is asserted is dropped with no response. ev_i is ignored during the reset cycle.

Read latency:
- Request accepted at edge T; address and status are sampled at T.
- wb_ack_o and wb_dat_o are valid for exactly one cycle after edge T+1.

Write latency:
- The write data and request are registered at T.
- The register update occurs at edge T+1.
- wb_ack_o is high after edge T+2 for one cycle.

Status and interrupt timing:
- An event pulse on ev_i at edge E is visible in status_o after E.
- The resulting irq_o rises after E+1.
- A clearing write that removes the last unmasked bit drops irq_o one cycle after the status clear.

## Configuration
Macro: ORCLR_IRQ_EN.

When defined:
- MASK registers and irq_o logic exist as described.

When undefined:
- No MASK flops are built.
- Offset 8k+4 is treated as unmapped and returns wb_err_o.
- irq_o is tied to 0.
- STATUS behaviour and timing are unchanged.

## Test plan
- Reset, then read STATUS[0] → ack after 2 cycles with data 0x00000000; all outputs 0.
- Pulse ev_i ch1 bits = 0x0000_00A5 for one cycle, then read offset 0x08 → 0x000000A5. Write 0x00000005 to 0x08, then read → 0x000000A0.
- Same-cycle set and clear: hold ev_i ch0 bit0 = 1 during the write update of 0x00000001 to 0x00 → STATUS[0] bit0 remains 1.
- With ORCLR_IRQ_EN: write MASK[2] = 0x1, pulse ch2 bit0 → irq_o = 1 two cycles later. Write 0x1 to STATUS[2] → irq_o = 0. Without the macro, irq_o stays 0 and offset 0x14 responds with err.
- With WIDTH = 8, N_CH = 2: write 0xFFFFFFFF to an unmapped offset 0x20 → err, no state change. Read STATUS[1] → bits [31:8] = 0.
- Assert rst_i during a write's pipeline cycle → no ack, registers 0 afterwards.
